wash_cycle_controller: RTL

Sequences one complete wash program: fill, wash, drain, rinse, and spin. It counts seconds from the divider's one-per-second enable pulse and drives the valve, motor, and pump control lines. It sits between the frequency divider and the actuator and display logic, running entirely on the system clock with tick enables rather than derived clocks.

---
 rtl/wash_pkg.sv | 61 ++++++
 rtl/wash_cycle_controller_if.sv | 34 +++
 rtl/wash_edge_detect.sv | 32 +++
 rtl/wash_cycle_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types for the wash cycle controller: phase/mode encodings, the
// seconds counter width and the per-mode program configuration.
package wash_pkg;

    localparam int SEC_W = 10;

    typedef logic [SEC_W-1:0] sec_t;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5,
        PH_DONE  = 3'd6
    } phase_t;

    typedef enum logic [1:0] {
        MODE_QUICK  = 2'd0,
        MODE_NORMAL = 2'd1,
        MODE_HEAVY  = 2'd2,
        MODE_SPIN   = 2'd3
    } mode_t;

    typedef struct packed {
        sec_t       wash_len;
        logic [1:0] rinses;
    } prog_cfg_t;

    // Quick mode halves the wash but never below one second.
    function automatic prog_cfg_t prog_cfg(input mode_t m, input sec_t wash_s);
        prog_cfg_t c;
        c.wash_len = wash_s;
        c.rinses   = 2'd2;
        case (m)
            MODE_QUICK: begin
                c.wash_len = (wash_s > sec_t'(1)) ? (wash_s >> 1) : sec_t'(1);
                c.rinses   = 2'd1;
            end
            MODE_NORMAL: begin
                c.wash_len = wash_s;
                c.rinses   = 2'd2;
            end
            MODE_HEAVY: begin
                c.wash_len = wash_s << 1;
                c.rinses   = 2'd3;
            end
            MODE_SPIN: begin
                c.wash_len = wash_s;
                c.rinses   = 2'd0;
            end
            default: begin
                c.wash_len = wash_s;
                c.rinses   = 2'd0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wash_cycle_controller_if.sv
// Control/status bundle between the wash controller and its surroundings
// (divider tick, front-panel inputs, actuator and display outputs).
interface wash_cycle_controller_if;
    import wash_pkg::*;

    logic       tick_1hz;
    logic       start;
    logic       pause;
    logic [1:0] mode;
    logic       lid_open;

    logic [2:0] phase;
    sec_t       sec_left;
    logic       paused;
    logic       valve_on;
    logic       motor_on;
    logic       motor_dir;
    logic       pump_on;
    logic       done;
    logic       alarm;

    modport master (
        output tick_1hz, start, pause, mode, lid_open,
        input  phase, sec_left, paused, valve_on, motor_on, motor_dir,
               pump_on, done, alarm
    );

    modport slave (
        input  tick_1hz, start, pause, mode, lid_open,
        output phase, sec_left, paused, valve_on, motor_on, motor_dir,
               pump_on, done, alarm
    );

endinterface

// File: rtl/wash_edge_detect.sv
// Registered rising-edge detector: edge_out pulses for one cycle in the
// cycle after sig_in is first sampled high.
module wash_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic edge_out
);

    logic prev_q, prev_d;
    logic edge_q, edge_d;

    // Next history and edge pulse.
    always_comb begin
        prev_d = sig_in;
        edge_d = sig_in & ~prev_q;
    end

    // History and edge registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign edge_out = edge_q;

endmodule

// File: rtl/wash_cycle_controller.sv
// Wash program sequencer (FILL/WASH/DRAIN/RINSE/SPIN/DONE) counting 1 Hz ticks.
// Optional lid interlock is enabled by defining WASH_LID_LOCK_EN.
module wash_cycle_controller #(
    parameter int FILL_S  = 10,
    parameter int WASH_S  = 30,
    parameter int DRAIN_S = 8,
    parameter int RINSE_S = 12,
    parameter int SPIN_S  = 15,
    parameter int DIR_S   = 4,
    parameter int ALARM_S = 3
) (
    input logic                   clk,
    input logic                   rst,
    wash_cycle_controller_if.slave bus
);
    import wash_pkg::*;

    localparam sec_t FILL_LEN  = sec_t'(FILL_S);
    localparam sec_t WASH_LEN  = sec_t'(WASH_S);
    localparam sec_t DRAIN_LEN = sec_t'(DRAIN_S);
    localparam sec_t RINSE_LEN = sec_t'(RINSE_S);
    localparam sec_t SPIN_LEN  = sec_t'(SPIN_S);
    localparam sec_t DIR_LEN   = sec_t'(DIR_S);
    localparam sec_t ALARM_LEN = sec_t'(ALARM_S);

    logic start_edge_s, pause_edge_s;
    logic running_s, start_ok_s, pause_hit_s, tick_ok_s, lid_force_s, run_d;
    prog_cfg_t start_cfg_s;

    phase_t     phase_q, phase_d;
    sec_t       sec_q, sec_d;
    sec_t       wash_len_q, wash_len_d;
    logic [1:0] rinse_q, rinse_d;
    sec_t       dir_cnt_q, dir_cnt_d;
    logic       dir_q, dir_d;
    logic       paused_q, paused_d;
    sec_t       alarm_cnt_q, alarm_cnt_d;
    logic       valve_q, valve_d;
    logic       motor_q, motor_d;
    logic       mdir_q, mdir_d;
    logic       pump_q, pump_d;
    logic       done_q, done_d;
    logic       alarm_q, alarm_d;

    wash_edge_detect u_start_edge (.clk(clk), .rst(rst), .sig_in(bus.start), .edge_out(start_edge_s));
    wash_edge_detect u_pause_edge (.clk(clk), .rst(rst), .sig_in(bus.pause), .edge_out(pause_edge_s));

    assign running_s = (phase_q != PH_IDLE) && (phase_q != PH_DONE);

`ifdef WASH_LID_LOCK_EN
    assign lid_force_s = running_s && bus.lid_open;
    assign start_ok_s  = start_edge_s && !running_s && !bus.lid_open;
`else
    logic lid_unused_s;
    assign lid_unused_s = bus.lid_open;
    assign lid_force_s  = 1'b0;
    assign start_ok_s   = start_edge_s && !running_s;
`endif

    // A pause edge always wins over a coincident tick, which is then dropped.
    assign pause_hit_s = running_s && pause_edge_s;
    assign tick_ok_s   = running_s && bus.tick_1hz && !paused_q && !pause_edge_s;
    assign start_cfg_s = prog_cfg(mode_t'(bus.mode), WASH_LEN);

    // Next-state sequencing and registered actuator decode.
    always_comb begin
        phase_d     = phase_q;
        sec_d       = sec_q;
        wash_len_d  = wash_len_q;
        rinse_d     = rinse_q;
        dir_cnt_d   = dir_cnt_q;
        dir_d       = dir_q;
        paused_d    = paused_q | lid_force_s;
        alarm_cnt_d = alarm_cnt_q;

        if (start_ok_s) begin
            wash_len_d  = start_cfg_s.wash_len;
            rinse_d     = start_cfg_s.rinses;
            paused_d    = 1'b0;
            dir_cnt_d   = sec_t'(0);
            dir_d       = 1'b0;
            alarm_cnt_d = sec_t'(0);
            if (mode_t'(bus.mode) == MODE_SPIN) begin
                phase_d = PH_DRAIN;
                sec_d   = DRAIN_LEN;
            end else begin
                phase_d = PH_FILL;
                sec_d   = FILL_LEN;
            end
        end else if (pause_hit_s) begin
            paused_d = lid_force_s | ~paused_q;
        end else if (tick_ok_s) begin
            if (sec_q > sec_t'(1)) begin
                sec_d = sec_q - sec_t'(1);
                if ((phase_q == PH_WASH) || (phase_q == PH_RINSE)) begin
                    if (dir_cnt_q == DIR_LEN - sec_t'(1)) begin
                        dir_cnt_d = sec_t'(0);
                        dir_d     = ~dir_q;
                    end else begin
                        dir_cnt_d = dir_cnt_q + sec_t'(1);
                    end
                end else begin
                    dir_cnt_d = dir_cnt_q;
                end
            end else begin
                dir_cnt_d = sec_t'(0);
                dir_d     = 1'b0;
                case (phase_q)
                    PH_FILL: begin
                        phase_d = PH_WASH;
                        sec_d   = wash_len_q;
                    end
                    PH_WASH, PH_RINSE: begin
                        phase_d = PH_DRAIN;
                        sec_d   = DRAIN_LEN;
                    end
                    PH_DRAIN: begin
                        if (rinse_q == 2'd0) begin
                            phase_d = PH_SPIN;
                            sec_d   = SPIN_LEN;
                        end else begin
                            phase_d = PH_RINSE;
                            sec_d   = RINSE_LEN;
                            rinse_d = rinse_q - 2'd1;
                        end
                    end
                    PH_SPIN: begin
                        phase_d     = PH_DONE;
                        sec_d       = sec_t'(0);
                        paused_d    = 1'b0;
                        alarm_cnt_d = ALARM_LEN;
                    end
                    default: begin
                        phase_d = PH_IDLE;
                        sec_d   = sec_t'(0);
                    end
                endcase
            end
        end else if ((phase_q == PH_DONE) && bus.tick_1hz) begin
            if (alarm_cnt_q != sec_t'(0)) begin
                alarm_cnt_d = alarm_cnt_q - sec_t'(1);
            end else begin
                alarm_cnt_d = alarm_cnt_q;
            end
        end else begin
            phase_d = phase_q;
        end

        run_d   = (phase_d != PH_IDLE) && (phase_d != PH_DONE) && !paused_d;
        valve_d = 1'b0;
        motor_d = 1'b0;
        mdir_d  = 1'b0;
        pump_d  = 1'b0;
        case (phase_d)
            PH_FILL: valve_d = run_d;
            PH_WASH, PH_RINSE: begin
                motor_d = run_d;
                mdir_d  = run_d & dir_d;
            end
            PH_DRAIN: pump_d = run_d;
            PH_SPIN: begin
                motor_d = run_d;
                pump_d  = run_d;
            end
            default: valve_d = 1'b0;
        endcase
        done_d  = (phase_d == PH_DONE);
        alarm_d = (phase_d == PH_DONE) && (alarm_cnt_d != sec_t'(0));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= PH_IDLE;
            sec_q       <= sec_t'(0);
            wash_len_q  <= sec_t'(0);
            rinse_q     <= 2'd0;
            dir_cnt_q   <= sec_t'(0);
            dir_q       <= 1'b0;
            paused_q    <= 1'b0;
            alarm_cnt_q <= sec_t'(0);
            valve_q     <= 1'b0;
            motor_q     <= 1'b0;
            mdir_q      <= 1'b0;
            pump_q      <= 1'b0;
            done_q      <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            sec_q       <= sec_d;
            wash_len_q  <= wash_len_d;
            rinse_q     <= rinse_d;
            dir_cnt_q   <= dir_cnt_d;
            dir_q       <= dir_d;
            paused_q    <= paused_d;
            alarm_cnt_q <= alarm_cnt_d;
            valve_q     <= valve_d;
            motor_q     <= motor_d;
            mdir_q      <= mdir_d;
            pump_q      <= pump_d;
            done_q      <= done_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.phase     = phase_q;
    assign bus.sec_left  = sec_q;
    assign bus.paused    = paused_q;
    assign bus.valve_on  = valve_q;
    assign bus.motor_on  = motor_q;
    assign bus.motor_dir = mdir_q;
    assign bus.pump_on   = pump_q;
    assign bus.done      = done_q;
    assign bus.alarm     = alarm_q;

endmodule
